// File: rtl/hs_burst_source.sv
// Valid/ready burst transmitter: emits len_in incrementing beats from seed_in,
// holding each beat stable until the receiver accepts it.
module hs_burst_source #(
   parameter int DATA_W = 3,
   parameter int LEN_W  = 4
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic [LEN_W-1:0]  len_in,
   input  logic [DATA_W-1:0] seed_in,
   input  logic              ready_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic              last_out,
   output logic              busy_out,
   output logic              done_out,
   output logic [7:0]        stall_cnt_out
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state, state_n;
   logic [LEN_W-1:0]  remaining, remaining_n;
   logic [DATA_W-1:0] data_n;
   logic              last_n;
   logic              done_n;
   logic [7:0]        stall_n;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state         <= IDLE;
         remaining     <= '0;
         valid_out     <= 1'b0;
         busy_out      <= 1'b0;
         data_out      <= '0;
         last_out      <= 1'b0;
         done_out      <= 1'b0;
         stall_cnt_out <= '0;
      end else begin
         state         <= state_n;
         remaining     <= remaining_n;
         // valid/busy are registered copies of the next state, so they never
         // see ready_in combinationally
         valid_out     <= (state_n == SEND);
         busy_out      <= (state_n == SEND);
         data_out      <= data_n;
         last_out      <= last_n;
         done_out      <= done_n;
         stall_cnt_out <= stall_n;
      end
   end

   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      data_n      = data_out;
      last_n      = last_out;
      done_n      = 1'b0;
      stall_n     = stall_cnt_out;
      unique case (state)
         IDLE: begin
            if (start_in) begin
               stall_n = '0;
               if (len_in != '0) begin
                  remaining_n = len_in;
                  data_n      = seed_in;
                  last_n      = (len_in == LEN_W'(1));
                  state_n     = SEND;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         SEND: begin
            if (ready_in) begin
               if (remaining == LEN_W'(1)) begin
                  state_n     = IDLE;
                  remaining_n = '0;
                  last_n      = 1'b0;
                  done_n      = 1'b1;
               end else begin
                  data_n      = data_out + DATA_W'(1);
                  remaining_n = remaining - LEN_W'(1);
                  last_n      = (remaining == LEN_W'(2));
               end
            end else if (stall_cnt_out != 8'hFF) begin
               stall_n = stall_cnt_out + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_hs_burst_source.sv
// Randomized bench for hs_burst_source against a beat-queue reference model.
module tb_hs_burst_source;

   localparam int DATA_W = 3;
   localparam int LEN_W  = 4;

   logic              sys_clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_in = 1'b0;
   logic [LEN_W-1:0]  len_in = '0;
   logic [DATA_W-1:0] seed_in = '0;
   logic              ready_in = 1'b0;
   logic              valid_out;
   logic [DATA_W-1:0] data_out;
   logic              last_out;
   logic              busy_out;
   logic              done_out;
   logic [7:0]        stall_cnt_out;

   always #5 sys_clk = ~sys_clk;

   hs_burst_source #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .sys_clk       (sys_clk),
      .rst           (rst),
      .start_in      (start_in),
      .len_in        (len_in),
      .seed_in       (seed_in),
      .ready_in      (ready_in),
      .valid_out     (valid_out),
      .data_out      (data_out),
      .last_out      (last_out),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .stall_cnt_out (stall_cnt_out)
   );

   typedef struct {
      int unsigned data;
      bit          last;
   } beat_t;

   // Reference model: the beats still owed to the receiver plus status
   beat_t       m_q[$];
   bit          m_busy  = 1'b0;
   bit          m_done  = 1'b0;
   int unsigned m_stall = 0;
   int unsigned m_hold  = 0;
   bit          chk_en  = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: check outputs, drive inputs for the next edge, advance model.
   task automatic cycle(input bit r, input bit s, input int unsigned len,
                        input int unsigned seed, input bit rdy);
      beat_t b;
      @(negedge sys_clk);
      if (chk_en) begin
         check("valid", 32'(valid_out), 32'(m_busy));
         check("busy", 32'(busy_out), 32'(m_busy));
         check("done", 32'(done_out), 32'(m_done));
         check("stall", 32'(stall_cnt_out), m_stall);
         if (m_busy) begin
            check("data", 32'(data_out), m_q[0].data);
            check("last", 32'(last_out), 32'(m_q[0].last));
         end else begin
            check("data_idle", 32'(data_out), m_hold);
            check("last_idle", 32'(last_out), 32'd0);
         end
      end
      rst      = r;
      start_in = s;
      len_in   = LEN_W'(len);
      seed_in  = DATA_W'(seed);
      ready_in = rdy;

      if (r) begin
         m_q.delete();
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_stall = 0;
         m_hold  = 0;
      end else if (!m_busy) begin
         m_done = 1'b0;
         if (s) begin
            m_stall = 0;
            if (len == 0) m_done = 1'b1;
            else begin
               for (int unsigned i = 0; i < len; i++) begin
                  b.data = (seed + i) % (1 << DATA_W);
                  b.last = (i == len - 1);
                  m_q.push_back(b);
               end
               m_busy = 1'b1;
            end
         end
      end else begin
         m_done = 1'b0;
         if (rdy) begin
            m_hold = m_q[0].data;
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (m_stall < 255) begin
            m_stall++;
         end
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1);
   endtask

   initial begin
      int unsigned len, seed, p, k;

      cycle(1'b1, 1'b0, 0, 0, 1'b0);
      chk_en = 1'b1;
      // start during reset is ignored
      cycle(1'b1, 1'b1, 3, 2, 1'b1);
      idle(2);

      // streaming burst 5,6,7,0
      cycle(1'b0, 1'b1, 4, 5, 1'b1);
      idle(6);

      // intermittent ready, one high cycle in three
      cycle(1'b0, 1'b1, 3, 0, 1'b1);
      for (int unsigned i = 0; i < 12; i++) cycle(1'b0, 1'b0, 0, 0, (i % 3) == 0);
      idle(2);

      // zero-length burst
      cycle(1'b0, 1'b1, 0, 3, 1'b1);
      idle(3);

      // starts while busy are ignored
      cycle(1'b0, 1'b1, 2, 6, 1'b0);
      cycle(1'b0, 1'b1, 7, 1, 1'b0);
      cycle(1'b0, 1'b1, 9, 2, 1'b1);
      cycle(1'b0, 1'b0, 0, 0, 1'b1);
      idle(3);

      // reset mid-burst, then a normal restart
      cycle(1'b0, 1'b1, 5, 4, 1'b1);
      cycle(1'b0, 1'b0, 0, 0, 1'b1);
      cycle(1'b0, 1'b0, 0, 0, 1'b1);
      cycle(1'b1, 1'b0, 0, 0, 1'b1);
      idle(2);
      cycle(1'b0, 1'b1, 3, 1, 1'b1);
      idle(5);

      // back-to-back with start held high
      for (int unsigned i = 0; i < 12; i++) cycle(1'b0, 1'b1, 2, i, 1'b1);
      idle(4);

      // stall counter saturation
      cycle(1'b0, 1'b1, 1, 7, 1'b0);
      for (int unsigned i = 0; i < 262; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0);
      idle(3);

      // randomized bursts, stray starts, occasional reset
      for (int unsigned t = 0; t < 60; t++) begin
         len  = $urandom_range(0, 15);
         seed = $urandom_range(0, 7);
         p    = $urandom_range(1, 4);
         cycle(1'b0, 1'b1, len, seed, $urandom_range(0, 1) == 1);
         k = 0;
         while (m_busy && k < 300) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3) < p);
            k++;
         end
         check("burst_bound", 32'(m_busy), 32'd0);
         idle($urandom_range(0, 2));
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hs_burst_source.md
# hs_burst_source

Transmitter end of the valid/ready bus handshake: generates bursts of incrementing data beats and drives `valid_out`/`data_out` toward a ready-driven receiver. It never drops or alters a beat while the receiver stalls. A start request launches a burst of `len_in` beats beginning at `seed_in`. Status outputs report busy, completion and stall cycles. It sits opposite the handshake receiver/counter in the bus-handshake labs and pairs with it in the same top-level bench.

## Interface
- `DATA_W`, 3: width of the beat payload.
- `LEN_W`, 4: width of the burst-length field. Maximum burst is 2^LEN_W − 1 beats.
- `sys_clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_in`  in  1  burst request, sampled only in IDLE.
- `len_in`  in  LEN_W  number of beats in the burst, captured with `start_in`.
- `seed_in`  in  DATA_W  first beat value, captured with `start_in`.
- `ready_in`  in  1  receiver ready.
- `valid_out`  out  1  beat valid.
- `data_out`  out  DATA_W  beat payload.
- `last_out`  out  1  marks the final beat of the burst; qualified by `valid_out`.
- `busy_out`  out  1  high while in SEND.
- `done_out`  out  1  one-cycle pulse when a burst ends.
- `stall_cnt_out`  out  8  count of cycles with `valid_out` high and `ready_in` low in the current/last burst.

## Operation
- FSM states:
  - IDLE: `valid_out` = 0.
  - SEND: `valid_out` = 1.
- All outputs are registered. `ready_in` feeds only next-state logic.
- **IDLE, `start_in` = 1, `len_in` ≠ 0:**
  - Capture `remaining` = `len_in` and `data_out` = `seed_in`.
  - Clear `stall_cnt_out`.
  - `last_out` = (`len_in` == 1).
  - Go to SEND.
- **IDLE, `start_in` = 1, `len_in` = 0:**
  - Stay in IDLE; no beat is emitted.
  - Pulse `done_out` for one cycle.
  - Clear `stall_cnt_out`.
- **SEND, handshake (`valid_out` & `ready_in`):**
  - If `remaining` == 1: go to IDLE, `valid_out` → 0, `last_out` → 0, pulse `done_out`.
  - Otherwise: `data_out` ← `data_out` + 1 (mod 2^DATA_W, wraps 7→0 at the default width), `remaining` ← `remaining` − 1, `last_out` ← (`remaining` == 2).
- **SEND, no handshake:**
  - `valid_out`, `data_out` and `last_out` hold exactly.
  - `stall_cnt_out` increments, saturating at 255.
- Protocol rules:
  - `valid_out` never deasserts without a handshake.
  - `valid_out` never depends combinationally on `ready_in`.
- `start_in` is ignored while in SEND; requests are not queued.
- `rst` mid-burst: return to IDLE on the next edge and abandon the burst. There is no `done_out` pulse.
- Reset values: state IDLE, `valid_out` 0, `data_out` 0, `last_out` 0, `busy_out` 0, `done_out` 0, `stall_cnt_out` 0, `remaining` 0.

## Timing
- Start latency: `start_in` sampled at edge k → `valid_out`, `data_out` = seed, `busy_out` high from edge k onward (visible in cycle k+1).
- Throughput: one beat per cycle while `ready_in` stays high.
- A burst of N beats with no stalls occupies exactly N cycles of `valid_out`.
- Final handshake at edge m → `valid_out` = 0 and `done_out` = 1 during cycle m+1. `done_out` clears at edge m+2.
- Earliest restart: a `start_in` sampled at edge m+1 gives `valid_out` again at m+2. There is a one-cycle bubble between bursts.
- `ready_in` may toggle every cycle. Each high cycle with `valid_out` high is exactly one beat.

## Test plan
- **Reset:** hold `rst` for 2 cycles mid-operation → all outputs 0, state IDLE; `start_in` during `rst` is ignored.
- **Streaming burst:** `len_in`=4, `seed_in`=5, `ready_in` always 1 → `data_out` 5,6,7,0 on 4 consecutive cycles; `last_out` only on beat 0; `done_out` pulse; `stall_cnt_out`=0.
- **Intermittent ready:** `len_in`=3, `seed_in`=0, `ready_in` high one cycle in every three (1-low-low) → beats 0,1,2 each held stable through their low cycles; `stall_cnt_out`=4; `valid_out` never drops early.
- **Zero-length and ignored start:** `len_in`=0 → no `valid_out`, single `done_out`. Then `start_in` pulsed while busy in a `len_in`=2 burst → exactly 2 beats emitted.
- **Reset mid-burst:** `len_in`=5, assert `rst` after beat 2 → `valid_out`=0 next cycle, no `done_out`, a new start works normally.
- **Back-to-back:** `start_in` held high continuously with `len_in`=2 → bursts separated by exactly one idle cycle; `done_out` pulses once per burst.
